// File: rtl/div_seq.sv
// Purpose : iterative 32-step restoring divider for DIV/DIVU, result as {remainder, quotient}.
// Latency : request accepted at cycle 0, out_valid first high in cycle WIDTH+3; one operation in flight.
// Backpres: in_ready low while busy; result held in DONE until out_ready; flush cancels at the next edge.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           div_op,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    // HI half carries the remainder, LO half the quotient.
    typedef struct packed {
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] quo;
    } res_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;          // dividend as captured (needed for divide-by-zero result)
    logic [WIDTH-1:0]   dvs_q, dvs_d;          // divisor as captured
    logic               sgn_q, sgn_d;          // 1 = signed DIV
    logic               dvd_neg_q, dvd_neg_d;
    logic               dvs_neg_q, dvs_neg_d;
    logic [WIDTH-1:0]   dvs_mag_q, dvs_mag_d;
    // Stored remainder is always below the divisor magnitude, so WIDTH bits hold it;
    // the extra bit of the 33-bit partial remainder exists only in rem_sh/trial.
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    res_t               res_q, res_d;

    logic               accept;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = res_q;
    assign accept    = in_valid & in_ready & (div_op != 2'b00) & ~flush;

    // Next-state, datapath step and result correction.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        sgn_d     = sgn_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        dvs_mag_d = dvs_mag_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        res_d     = res_q;

        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, dvs_mag_q};
        quo_fix = (sgn_q && (dvd_neg_q ^ dvs_neg_q)) ? -quo_q : quo_q;
        rem_fix = (sgn_q && dvd_neg_q) ? -rem_q : rem_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dvd_d     = dividend;
                    dvs_d     = divisor;
                    sgn_d     = div_op[0];   // signed wins when both bits set
                    dvd_neg_d = dividend[WIDTH-1];
                    dvs_neg_d = divisor[WIDTH-1];
                    state_d   = S_PREP;
                end
            end
            S_PREP: begin
                quo_d     = (sgn_q && dvd_neg_q) ? -dvd_q : dvd_q;
                dvs_mag_d = (sgn_q && dvs_neg_q) ? -dvs_q : dvs_q;
                rem_d     = '0;
                cnt_d     = '0;
                state_d   = S_ITER;
            end
            S_ITER: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // A cancelled division must not disturb the held result.
                if (!flush) begin
                    if (dvs_q == '0) begin
                        res_d = '{rem: dvd_q, quo: '1};
                    end else begin
                        res_d = '{rem: rem_fix, quo: quo_fix};
                    end
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers; synchronous active-low reset beats flush.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            sgn_q     <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            dvs_mag_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            sgn_q     <= sgn_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            dvs_mag_q <= dvs_mag_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            res_q     <= res_d;
        end
    end

endmodule
